// File: rtl/scan_pkg.sv
// scan_pkg: shared state encoding, default chain length and counter width helpers for the scan chain master.
package scan_pkg;
  typedef enum logic [2:0] {IDLE, LO, HI, GAP, LOAD, RESP} state_e;
  localparam int SC_SIZE_DEFAULT = 128;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/scan_phase_timer.sv
// scan_phase_timer: loadable down-counter; done is high on the last cycle of a phase of len cycles.
module scan_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W:0]   len,
  output logic         done
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = start ? W'(len - (W+1)'(1)) : ((cnt_q != '0) ? cnt_q - W'(1) : cnt_q);
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign done = (cnt_q == '0);
endmodule

// File: rtl/scan_chain_master.sv
// scan_chain_master: serializes a config word onto the two-latch scan chain, optional load pulse, returns old contents.
// Readback of the old chain contents is built only when SCAN_CHAIN_MASTER_READBACK_EN is defined.
module scan_chain_master
  import scan_pkg::*;
#(
  parameter int SC_SIZE     = SC_SIZE_DEFAULT,
  parameter int CLK_DIV     = 4,
  parameter int LOAD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [SC_SIZE-1:0] cmd_data,
  input  logic               cmd_load,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [SC_SIZE-1:0] rsp_data,
  output logic               busy,
  output logic               scan_clk,
  output logic               scan_data_in,
  input  logic               scan_data_out,
  output logic               scan_load_chip
);
  localparam int BW = cnt_w(SC_SIZE);
  localparam int PW = cnt_w(max2(CLK_DIV, LOAD_CYCLES));
  localparam int LW = PW + 1;
  state_e st_q, st_d;
  logic [SC_SIZE-1:0] sh_q, sh_d;
  logic [BW-1:0] bit_q, bit_d;
  logic ld_q, ld_d, done, start;
  logic [LW-1:0] len;
  always_comb begin
    st_d  = st_q;
    sh_d  = sh_q;
    bit_d = bit_q;
    ld_d  = ld_q;
    case (st_q)
      IDLE: if (cmd_valid && cmd_ready) begin
        st_d  = LO;
        sh_d  = cmd_data;
        bit_d = '0;
        ld_d  = cmd_load;
      end
      LO:   if (done) st_d = HI;
      HI:   if (done) begin
        sh_d = sh_q >> 1;
        if (bit_q == BW'(SC_SIZE - 1)) st_d = ld_q ? GAP : RESP;
        else begin
          bit_d = bit_q + BW'(1);
          st_d  = LO;
        end
      end
      GAP:  if (done) st_d = LOAD;
      LOAD: if (done) st_d = RESP;
      RESP: if (rsp_ready) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end
  // every state change restarts the phase timer for the state being entered
  assign start = (st_d != st_q);
  assign len   = (st_d == LOAD) ? LW'(LOAD_CYCLES) : LW'(CLK_DIV);
  scan_phase_timer #(.W(PW)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .len  (len),
    .done (done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= IDLE;
      sh_q  <= '0;
      bit_q <= '0;
      ld_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      sh_q  <= sh_d;
      bit_q <= bit_d;
      ld_q  <= ld_d;
    end
  end
  assign busy           = (st_q != IDLE);
  assign cmd_ready      = (st_q == IDLE) && !rst;
  assign rsp_valid      = (st_q == RESP);
  assign scan_clk       = (st_q == HI) && !rst;
  assign scan_load_chip = (st_q == LOAD) && !rst;
  assign scan_data_in   = sh_q[0];
`ifdef SCAN_CHAIN_MASTER_READBACK_EN
  logic sd_q;
  logic [SC_SIZE-1:0] rb_q;
  // old chain bit enters from the top so the first bit read ends in rb bit 0
  always_ff @(posedge clk) begin
    if (rst) begin
      sd_q <= 1'b0;
      rb_q <= '0;
    end else begin
      sd_q <= scan_data_out;
      if (st_q == LO && done) rb_q <= {sd_q, rb_q[SC_SIZE-1:1]};
    end
  end
  assign rsp_data = (st_q == RESP) ? rb_q : '0;
`else
  logic unused_sdo;
  assign unused_sdo = scan_data_out;
  assign rsp_data   = '0;
`endif
endmodule

// File: tb/tb_scan_chain_master.sv
// tb_scan_chain_master: directed plus random commands against a behavioural two-latch chip model.
module tb_scan_chain_master;
  localparam int SC = 8;
  localparam int CD = 2;
  localparam int LC = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_load = 1'b0, rsp_ready = 1'b0;
  logic [SC-1:0] cmd_data = '0;
  logic cmd_ready, rsp_valid, busy, scan_clk, scan_data_in, scan_data_out, scan_load_chip;
  logic [SC-1:0] rsp_data;
  logic [SC-1:0] chain = 8'h3C;
  logic [SC-1:0] shadow = '0;
  int rises = 0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  scan_chain_master #(.SC_SIZE(SC), .CLK_DIV(CD), .LOAD_CYCLES(LC)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_load(cmd_load), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .scan_clk(scan_clk), .scan_data_in(scan_data_in), .scan_data_out(scan_data_out),
    .scan_load_chip(scan_load_chip)
  );
  assign scan_data_out = chain[0];
  always @(posedge scan_clk) begin
    chain <= {scan_data_in, chain[SC-1:1]};
    rises <= rises + 1;
  end
  always @(posedge clk) if (scan_load_chip) shadow <= chain;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [SC-1:0] exp_rsp(input logic [SC-1:0] old);
`ifdef SCAN_CHAIN_MASTER_READBACK_EN
    return old;
`else
    return '0;
`endif
  endfunction
  task automatic issue(input logic [SC-1:0] d, input logic l, output logic [SC-1:0] old, output int r0);
    int b;
    @(negedge clk);
    cmd_data = d; cmd_load = l; cmd_valid = 1'b1; b = 0;
    while (!cmd_ready && b < 100) begin
      @(negedge clk);
      b++;
    end
    check("accept_wait", 32'(b < 100), 32'd1);
    @(posedge clk);
    #1;
    old = chain; r0 = rises;
    cmd_valid = 1'b0; cmd_data = SC'($urandom); cmd_load = 1'($urandom);
  endtask
  task automatic wait_rsp(output int n, output int first, output int cnt);
    n = 0; first = -1; cnt = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      if (scan_load_chip) begin
        if (first < 0) first = n;
        cnt++;
      end
    end while (!rsp_valid && n < 400);
  endtask
  task automatic finish_rsp(input int hold, input logic [SC-1:0] exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
      check("rsp_hold_data", 32'(rsp_data), 32'(exp));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rsp_done_valid", 32'(rsp_valid), 32'd0);
    check("rsp_done_busy", 32'(busy), 32'd0);
  endtask
  task automatic full(input logic [SC-1:0] d, input logic l, input int hold);
    logic [SC-1:0] old, sh0;
    int r0, n, first, cnt;
    sh0 = shadow;
    issue(d, l, old, r0);
    wait_rsp(n, first, cnt);
    check("latency", 32'(n), 32'(2*CD*SC + (l ? CD + LC : 0)));
    check("load_cycles", 32'(cnt), l ? 32'(LC) : 32'd0);
    if (l) check("load_first", 32'(first), 32'(2*CD*SC + CD));
    check("scan_rises", 32'(rises - r0), 32'(SC));
    check("chain", 32'(chain), 32'(d));
    check("chip_out", 32'(shadow), l ? 32'(d) : 32'(sh0));
    check("rsp_data", 32'(rsp_data), 32'(exp_rsp(old)));
    finish_rsp(hold, exp_rsp(old));
  endtask
  initial begin
    logic [SC-1:0] old, old2, held;
    int r0, n, first, cnt;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_scan_clk", 32'(scan_clk), 32'd0);
    check("rst_scan_din", 32'(scan_data_in), 32'd0);
    check("rst_load", 32'(scan_load_chip), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_ready", 32'(cmd_ready), 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("stray_rsp_ready", 32'(busy), 32'd0);
    full(8'hA5, 1'b0, 0);
    full(8'h81, 1'b1, 3);
    // back-pressure: a second command waits behind an unconsumed response
    issue(8'h5A, 1'b0, old, r0);
    wait_rsp(n, first, cnt);
    check("bp_latency", 32'(n), 32'(2*CD*SC));
    held = rsp_data;
    check("bp_rsp", 32'(held), 32'(exp_rsp(old)));
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 8'hC3; cmd_load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_data_stable", 32'(rsp_data), 32'(held));
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("bp_idle_ready", 32'(cmd_ready), 32'd1);
    old2 = chain;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("bp_accepted", 32'(busy), 32'd1);
    wait_rsp(n, first, cnt);
    check("bp2_latency", 32'(n), 32'(2*CD*SC));
    check("bp2_chain", 32'(chain), 32'hC3);
    check("bp2_rsp", 32'(rsp_data), 32'(exp_rsp(old2)));
    finish_rsp(0, exp_rsp(old2));
    // reset in the middle of a shift
    issue(SC'($urandom), 1'b0, old, r0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_scan_clk", 32'(scan_clk), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (40) @(posedge clk);
    #1;
    check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    full(8'hFF, 1'b0, 0);
    for (int i = 0; i < 6; i++) full(SC'($urandom), 1'($urandom), int'($urandom_range(0, 4)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/scan_chain_master.md
Name: scan_chain_master

Overview:
- Host-side driver for the chip's two-latch scan chain.
- Accepts a parallel configuration word over a valid/ready handshake and serializes it onto the scan pads, generating the scan clock from the system clock.
- Optionally pulses the chip load strobe after the shift, then returns the chain's previous contents (shifted out during the same pass) over a response handshake.
- Sits between the config/CSR fabric and the scan pads.

Parameters:
- SC_SIZE, 128, scan chain length in bits; must equal the chip chain length.
- CLK_DIV, 4, scan clock half-period in clk cycles; minimum 2.
- LOAD_CYCLES, 2, width of the scan_load_chip pulse in clk cycles; minimum 1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid and ready are both high.
- cmd_data  in  SC_SIZE  word to shift in; bit 0 is shifted first and ends in chain bit 0.
- cmd_load  in  1  pulse scan_load_chip after the shift.
- rsp_valid  out  1  readback word available.
- rsp_ready  in  1  response consumed when valid and ready are both high.
- rsp_data  out  SC_SIZE  previous chain contents; bit i is the old chain bit i.
- busy  out  1  high in every state except IDLE.
- scan_clk  out  1  to chip clk pad.
- scan_data_in  out  1  to chip scan_data_in pad.
- scan_data_out  in  1  from chip scan_data_out pad (chain bit 0).
- scan_load_chip  out  1  to chip load pad.

Behaviour:
- Reset: all outputs 0 (cmd_ready, rsp_valid, rsp_data, busy, scan_clk, scan_data_in, scan_load_chip); state IDLE; all counters 0.
- States: IDLE, LO, HI, GAP, LOAD, RESP.
- IDLE: cmd_ready = !rsp_valid. On accept, sh <= cmd_data, bit_cnt <= 0, ph_cnt <= 0, go to LO.
- LO: scan_clk=0, scan_data_in=sh[0], held for CLK_DIV cycles.
  - scan_data_out is registered once.
  - On the last LO cycle the registered bit is shifted into rb from the MSB side: rb <= {sd_q, rb[SC_SIZE-1:1]}.
  - Then go to HI.
- HI: scan_clk=1, scan_data_in held, for CLK_DIV cycles. On the last HI cycle:
  - sh >>= 1.
  - If bit_cnt == SC_SIZE-1: go to GAP if the latched cmd_load is 1, else go to RESP.
  - Otherwise bit_cnt++ and go to LO.
- Data stability: scan_data_in changes only on entry to LO, so it is stable for a full half-period on each side of every scan_clk rise.
- GAP: scan_clk=0 for CLK_DIV cycles; the chip slave latch settles after the final fall.
- LOAD: scan_load_chip=1 for exactly LOAD_CYCLES cycles, then go to RESP.
- RESP: rsp_valid=1 and rsp_data=rb. Hold until rsp_ready, then go to IDLE. rsp_data stays stable while valid.
- Latency from accept to rsp_valid: 2*CLK_DIV*SC_SIZE + (cmd_load ? CLK_DIV+LOAD_CYCLES : 0) cycles.
- cmd_data and cmd_load are latched at accept; later changes on the inputs are ignored.
- cmd_valid while busy: cmd_ready stays low and the command is not lost (it waits on the handshake).
- rsp_ready asserted outside RESP: ignored.
- Same-cycle response accept and new command: not possible, because cmd_ready is only high in IDLE. Minimum 1 idle cycle between commands.
- Reset mid-operation: state returns to IDLE on the next edge and scan_clk/scan_load_chip drop low immediately. The partial chain content is undefined; the host must reissue. No response is produced for an aborted command.
- Counter widths: bit_cnt is $clog2(SC_SIZE) bits, ph_cnt is $clog2(max(CLK_DIV,LOAD_CYCLES)) bits. No wrap: the terminal compare is at SC_SIZE-1.

Optional Feature:
- Macro: SCAN_CHAIN_MASTER_READBACK_EN.
- Defined: rb shift register, scan_data_out input flop and rsp_data behave as above.
- Undefined: rb and the input flop are not built, rsp_data is tied to 0, scan_data_out is unused, and the handshake and timing are unchanged.

Decomposition:
- Shared package scan_pkg holds:
  - the state enum (IDLE, LO, HI, GAP, LOAD, RESP);
  - SC_SIZE_DEFAULT = 128;
  - a width helper for counters.
- One sub-module, scan_phase_timer: loadable down-counter taking (clk, rst, start, len) and producing a done pulse. It is reused for the LO, HI, GAP and LOAD durations.

Test Plan:
- Bench setup for all scenarios: SC_SIZE=8, CLK_DIV=2, LOAD_CYCLES=2, behavioural chip model, chain preloaded with 8'h3C.
- Plain shift, no load: cmd_data=8'hA5, cmd_load=0.
  - Bits 1,0,1,0,0,1,0,1 appear on scan_data_in, one per scan_clk rise.
  - Chain = A5; load pin never rises.
  - rsp_valid at cycle 32 after accept with rsp_data=3C.
- Shift with load: cmd_data=8'h81, cmd_load=1.
  - scan_load_chip high for cycles 34-35.
  - Chip output = 81.
  - rsp_valid at cycle 36 with rsp_data equal to the prior chain contents.
- Back-pressure: hold rsp_ready=0 for 10 cycles with cmd_valid=1 and a new word present.
  - rsp_data stable; cmd_ready=0; second command accepted only after rsp handshake plus 1 cycle.
- Reset mid-shift: assert rst at cycle 9.
  - Next cycle: scan_clk=0, busy=0, rsp_valid=0, cmd_ready=1.
  - A fresh cmd 8'hFF then completes normally.
- Readback macro off: repeat the plain shift scenario; rsp_data=0, timing identical.
